z16_load_store_unit: RTL and testbench
======================================

# z16_load_store_unit

Initiator side of the Z16 data-memory port: accepts byte/word load and store requests from the execute stage over a valid/ready handshake and drives the word-organised data memory (combinational read, write on clock edge, byte address with bit 0 ignored). Byte stores use read-modify-write. Unaligned word accesses are split into two memory accesses when enabled. Sits between the Z16 pipeline and the data memory.

## Interface
- No parameters; the data path is 16-bit and addresses are 16-bit byte addresses.
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_byte  in  1  1 = byte access, 0 = word access
- i_req_addr  in  16  byte address
- i_req_wdata  in  16  store data; byte stores use [7:0]
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  16  load data; byte loads are zero-extended; 0 for stores
- o_rsp_err  out  1  qualified by o_rsp_valid
- o_mem_addr  out  16  word byte-address; bit 0 always 0
- o_mem_we  out  1  memory write enable
- o_mem_wdata  out  16  memory write data
- i_mem_rdata  in  16  combinational read data for o_mem_addr

## Operation
- **Byte lanes:** little-endian.
  - Even byte address maps to word bits [7:0]; odd maps to [15:8].
  - Word index = addr[15:1].
- **Handshake:** a request is accepted on an edge where i_req_valid and o_req_ready are both high. The request is latched and the FSM leaves IDLE.
- **FSM states:** IDLE, RD_LO, WR_LO, RD_HI, WR_HI, RESP.
- **Aligned word load:** IDLE → RD_LO → RESP.
- **Byte load:** IDLE → RD_LO → RESP. The lane is selected by addr[0].
- **Aligned word store:** IDLE → WR_LO → RESP.
- **Byte store:** IDLE → RD_LO → WR_LO → RESP. Merge the new byte into the read word and write it back, preserving the other lane.
- **Unaligned word load (addr[0]=1):** IDLE → RD_LO → RD_HI → RESP.
  - Result low byte = word(addr)[15:8].
  - Result high byte = word(addr+1)[7:0].
- **Unaligned word store:** IDLE → RD_LO → WR_LO → RD_HI → WR_HI → RESP.
  - wdata[7:0] goes to the high lane of the first word.
  - wdata[15:8] goes to the low lane of the second word.
- **Memory port drive:**
  - o_mem_addr = {word_idx,1'b0}.
  - The HI phases use word_idx+1, modulo 2^15. Address 0xFFFF therefore wraps to 0x0000.
  - o_mem_we is high only in WR_LO and WR_HI.
  - All o_mem_* outputs decode from registered state and latched request only. There is no path from i_req_* to them.
- **Read capture:** i_mem_rdata is captured at the end of each RD_* cycle.
- **RESP state:** o_rsp_valid=1, o_req_ready=0, then return to IDLE.
- **o_rsp_rdata / o_rsp_err:** hold their values until the next RESP.
- **Reset:** async reset clears everything. Values:
  - state = IDLE, so o_req_ready = 1
  - o_rsp_valid, o_rsp_err, o_rsp_rdata = 0
  - o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0
- **Reset mid-operation:** aborts the operation and produces no response. An unaligned store aborted after WR_LO leaves its first word written; this is accepted behaviour.

## Timing
- Latency is counted from the acceptance edge E0 to the cycle in which o_rsp_valid is high:
  - aligned word load, byte load, word store: 2 cycles
  - byte store, unaligned load: 3 cycles
  - unaligned store: 5 cycles
- Back-to-back: the earliest next acceptance is the edge that ends RESP, because o_req_ready is low in RESP.
- i_req_* are don't-care outside acceptance edges.

## Configuration
- **Macro:** Z16_LSU_UNALIGNED_EN.
- **Defined:** unaligned word accesses are split as described in Operation.
- **Undefined:**
  - An unaligned word request goes IDLE → RESP with o_rsp_err=1 and o_rsp_rdata=0, latency 1.
  - No memory access is made and o_mem_we stays low.
  - RD_HI and WR_HI are not synthesised.
- Byte accesses are never errors.

## Structure
- **Package z16_lsu_pkg:**
  - state enum
  - address/data width constants (16)
  - lane select constants
- **Sub-module z16_byte_lane:** purely combinational.
  - Byte extract, with zero-extend, from a word and lane.
  - Byte merge into a word for a lane.
- The FSM and registers stay in z16_load_store_unit.

## Test plan
Memory is preloaded with word@0x0002=0x0010 and word@0x0004=0x0020; all other words are 0.
- Word load at addr 0x0002 → o_rsp_rdata=0x0010 two cycles after accept; o_mem_we never high.
- Byte loads at 0x0002, then at 0x0003 → 0x0010, then 0x0000.
- Byte store 0x??AB at 0x0005 → one RD_LO then one WR_LO with o_mem_wdata=0xAB20; a following word load at 0x0004 returns 0xAB20.
- Unaligned word load at 0x0003 (macro defined) → 0x2000 at latency 3; unaligned store 0x1234 at 0x0007 → word@0x0006 high lane=0x34 and word@0x0008 low lane=0x12, other lanes unchanged.
- Unaligned word load at 0xFFFF (macro defined) → second access at o_mem_addr=0x0000. With the macro undefined → o_rsp_err=1 at latency 1 and no memory cycle.
- Assert i_rst during WR_LO of a byte store → all outputs are 0 and o_req_ready=1 immediately; no o_rsp_valid; a new request is accepted on the first edge after reset release.

Source files
------------

// File: rtl/z16_lsu_pkg.sv
// Shared types and constants for the Z16 load/store unit.
// Optional feature macro: Z16_LSU_UNALIGNED_EN (split unaligned word accesses).
package z16_lsu_pkg;

    localparam int unsigned XLEN   = 16;
    localparam int unsigned ADDR_W = 16;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_WR_LO,
        ST_RD_HI,
        ST_WR_HI,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/z16_byte_lane.sv
// Little-endian byte lane helper: zero-extended extract and lane merge.
// Purely combinational.
module z16_byte_lane
    import z16_lsu_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic            lane_i,
    input  logic [7:0]      byte_i,
    output logic [XLEN-1:0] ext_o,
    output logic [XLEN-1:0] merge_o
);

    always_comb begin
        if (lane_i == LANE_HI) begin
            ext_o   = {8'h00, word_i[15:8]};
            merge_o = {byte_i, word_i[7:0]};
        end else begin
            ext_o   = {8'h00, word_i[7:0]};
            merge_o = {word_i[15:8], byte_i};
        end
    end

endmodule

// File: rtl/z16_load_store_unit.sv
// Z16 data-memory initiator: byte/word loads and stores, RMW byte stores.
// Optional feature macro: Z16_LSU_UNALIGNED_EN (split unaligned word accesses).
module z16_load_store_unit
    import z16_lsu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic              i_req_byte,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_rsp_valid,
    output logic [XLEN-1:0]   o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic [XLEN-1:0]   i_mem_rdata
);

    lsu_state_e state_q, state_d;

    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0] lane_word;
    logic            lane_sel;
    logic [7:0]      lane_byte;
    logic [XLEN-1:0] lane_ext;
    logic [XLEN-1:0] lane_merge;
    logic [ADDR_W-1:0] lo_addr;

`ifdef Z16_LSU_UNALIGNED_EN
    logic              unal_q;
    logic [ADDR_W-2:0] hi_idx;
    assign unal_q = !byte_q && addr_q[0];
    assign hi_idx = addr_q[ADDR_W-1:1] + 15'd1;
`endif

    assign lo_addr = {addr_q[ADDR_W-1:1], 1'b0};

    // Extract in RD_LO reads the live word; merges use the captured word.
    always_comb begin
        lane_word = (state_q == ST_RD_LO) ? i_mem_rdata : rd_q;
        lane_byte = (state_q == ST_WR_HI) ? wdata_q[15:8] : wdata_q[7:0];
        if (state_q == ST_WR_HI) begin
            lane_sel = LANE_LO;
        end else if (byte_q) begin
            lane_sel = addr_q[0];
        end else begin
            lane_sel = LANE_HI;
        end
    end

    z16_byte_lane u_lane (
        .word_i  (lane_word),
        .lane_i  (lane_sel),
        .byte_i  (lane_byte),
        .ext_o   (lane_ext),
        .merge_o (lane_merge)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    byte_d  = i_req_byte;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    if (!i_req_byte && i_req_addr[0]) begin
`ifdef Z16_LSU_UNALIGNED_EN
                        state_d = ST_RD_LO;
`else
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
`endif
                    end else if (i_req_we && !i_req_byte) begin
                        state_d = ST_WR_LO;
                    end else begin
                        state_d = ST_RD_LO;
                    end
                end
            end
            ST_RD_LO: begin
                rd_d = i_mem_rdata;
                if (we_q) begin
                    state_d = ST_WR_LO;
`ifdef Z16_LSU_UNALIGNED_EN
                end else if (unal_q) begin
                    state_d = ST_RD_HI;
`endif
                end else begin
                    rdata_d = byte_q ? lane_ext : i_mem_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_WR_LO: begin
`ifdef Z16_LSU_UNALIGNED_EN
                if (unal_q) begin
                    state_d = ST_RD_HI;
                end else begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
`else
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_RESP;
`endif
            end
`ifdef Z16_LSU_UNALIGNED_EN
            ST_RD_HI: begin
                rd_d = i_mem_rdata;
                if (we_q) begin
                    state_d = ST_WR_HI;
                end else begin
                    rdata_d = {i_mem_rdata[7:0], rd_q[15:8]};
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_WR_HI: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
`endif
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory port decodes only from registered state and latched request.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        unique case (state_q)
            ST_RD_LO: begin
                o_mem_addr = lo_addr;
            end
            ST_WR_LO: begin
                o_mem_addr  = lo_addr;
                o_mem_we    = 1'b1;
                o_mem_wdata = (byte_q || addr_q[0]) ? lane_merge : wdata_q;
            end
`ifdef Z16_LSU_UNALIGNED_EN
            ST_RD_HI: begin
                o_mem_addr = {hi_idx, 1'b0};
            end
            ST_WR_HI: begin
                o_mem_addr  = {hi_idx, 1'b0};
                o_mem_we    = 1'b1;
                o_mem_wdata = lane_merge;
            end
`endif
            default: begin
            end
        endcase
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_z16_load_store_unit.sv
// Directed bench for z16_load_store_unit with a word-organised memory model.
// Expectations follow Z16_LSU_UNALIGNED_EN when it is defined.
module tb_z16_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:32767];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;
    int          we_cnt;
    int          nlog;
    logic [15:0] last_wd;
    logic [15:0] alog [0:15];
    int          rv_seen;

    always #5 clk = ~clk;

    z16_load_store_unit dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_we    (req_we),
        .i_req_byte  (req_byte),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[15:1]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[15:1]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic we, input logic bt,
                           input logic [15:0] addr, input logic [15:0] wd,
                           input int exp_lat, input logic [15:0] exp_rd,
                           input logic exp_err, input int exp_we);
        @(negedge clk);
        chk({tag, ".rdy"}, 16'(req_ready), 16'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_byte  = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        lat    = 1;
        we_cnt = 0;
        nlog   = 0;
        while (!rsp_valid && lat < 12) begin
            if (mem_we) begin
                we_cnt++;
                last_wd = mem_wdata;
            end
            if (nlog < 16) begin
                alog[nlog] = mem_addr;
                nlog++;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, 16'(lat), 16'(exp_lat));
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, 16'(rsp_err), 16'(exp_err));
        chk({tag, ".we_cnt"}, 16'(we_cnt), 16'(exp_we));
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 16'(rsp_valid), 16'h0);
        chk({tag, ".hold"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[1] = 16'h0010;
        mem[2] = 16'h0020;
        last_wd   = '0;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", 16'(req_ready), 16'h1);
        chk("rst.rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst.rdata", rsp_rdata, 16'h0);
        chk("rst.err", 16'(rsp_err), 16'h0);
        chk("rst.mem_we", 16'(mem_we), 16'h0);
        chk("rst.mem_addr", mem_addr, 16'h0);
        chk("rst.mem_wdata", mem_wdata, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        run_req("wld2", 0, 0, 16'h0002, 16'h0, 2, 16'h0010, 0, 0);
        run_req("bld2", 0, 1, 16'h0002, 16'h0, 2, 16'h0010, 0, 0);
        run_req("bld3", 0, 1, 16'h0003, 16'h0, 2, 16'h0000, 0, 0);
        run_req("bst5", 1, 1, 16'h0005, 16'h77AB, 3, 16'h0000, 0, 1);
        chk("bst5.wdata", last_wd, 16'hAB20);
        run_req("wld4", 0, 0, 16'h0004, 16'h0, 2, 16'hAB20, 0, 0);
        run_req("wst6", 1, 0, 16'h0006, 16'h5566, 2, 16'h0000, 0, 1);
        run_req("wst8", 1, 0, 16'h0008, 16'h7788, 2, 16'h0000, 0, 1);
        run_req("wstfe", 1, 0, 16'hFFFE, 16'hBEEF, 2, 16'h0000, 0, 1);
        run_req("wst0", 1, 0, 16'h0000, 16'h1357, 2, 16'h0000, 0, 1);

`ifdef Z16_LSU_UNALIGNED_EN
        run_req("uld3", 0, 0, 16'h0003, 16'h0, 3, 16'h2000, 0, 0);
        run_req("ust7", 1, 0, 16'h0007, 16'h1234, 5, 16'h0000, 0, 2);
        chk("ust7.wdata2", last_wd, 16'h7712);
        run_req("rd6", 0, 0, 16'h0006, 16'h0, 2, 16'h3466, 0, 0);
        run_req("rd8", 0, 0, 16'h0008, 16'h0, 2, 16'h7712, 0, 0);
        run_req("uldff", 0, 0, 16'hFFFF, 16'h0, 3, 16'h57BE, 0, 0);
        chk("uldff.ncyc", 16'(nlog), 16'h2);
        chk("uldff.addr_lo", alog[0], 16'hFFFE);
        chk("uldff.addr_hi", alog[1], 16'h0000);
`else
        run_req("uld3", 0, 0, 16'h0003, 16'h0, 1, 16'h0000, 1, 0);
        run_req("ust7", 1, 0, 16'h0007, 16'h1234, 1, 16'h0000, 1, 0);
        run_req("rd6", 0, 0, 16'h0006, 16'h0, 2, 16'h5566, 0, 0);
        run_req("rd8", 0, 0, 16'h0008, 16'h0, 2, 16'h7788, 0, 0);
        run_req("uldff", 0, 0, 16'hFFFF, 16'h0, 1, 16'h0000, 1, 0);
        chk("uldff.ncyc", 16'(nlog), 16'h0);
`endif
        run_req("wld4b", 0, 0, 16'h0004, 16'h0, 2, 16'hAB20, 0, 0);

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b1;
        req_addr  = 16'h0004;
        req_wdata = 16'h0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort.in_wr", 16'(mem_we), 16'h1);
        rst = 1'b1;
        #1;
        chk("abort.ready", 16'(req_ready), 16'h1);
        chk("abort.rsp_valid", 16'(rsp_valid), 16'h0);
        chk("abort.rdata", rsp_rdata, 16'h0);
        chk("abort.err", 16'(rsp_err), 16'h0);
        chk("abort.mem_we", 16'(mem_we), 16'h0);
        chk("abort.mem_addr", mem_addr, 16'h0);
        chk("abort.mem_wdata", mem_wdata, 16'h0);
        rv_seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rv_seen++;
        end
        #1;
        rst = 1'b0;
        chk("abort.no_rsp", 16'(rv_seen), 16'h0);
        run_req("post", 0, 0, 16'h0004, 16'h0, 2, 16'hAB20, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
